wb_commit_stage: RTL and testbench
==================================

WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 Parameters SHALL be: LANES, default 2, issue width (1..4); DATA_W, default 32, data/PC width; RADDR_W, default 5, register address width; ECODE_W, default 6, exception code width; CNT_W, default 64, retire counter width.
REQ-002 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  stage clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 pre_valid_i  in  LANES  per-lane valid from the MEM stage; lane 0 is the oldest.
REQ-006 pre_pc_i, pre_wdata_i  in  LANES*DATA_W each  per-lane PC and result.
REQ-007 pre_we_i, pre_store_i, pre_excp_i  in  LANES each  per-lane regfile write, store, and exception flags.
REQ-008 pre_waddr_i  in  LANES*RADDR_W  destination registers; pre_ecode_i  in  LANES*ECODE_W  exception codes.
REQ-009 next_allowin_i  in  1  commit permitted this cycle (store buffer not full).
REQ-010 now_allowin_o  out  1  stage can accept a new group.
REQ-011 rf_we_o  out  LANES; rf_waddr_o  out  LANES*RADDR_W; rf_wdata_o  out  LANES*DATA_W: regfile write ports.
REQ-012 commit_valid_o  out  LANES; commit_pc_o  out  LANES*DATA_W: retired instructions.
REQ-013 store_commit_o  out  LANES  per-lane store buffer release.
REQ-014 excep_flush_o  out  1  pipeline flush request.
REQ-015 excp_pc_o  out  DATA_W; excp_ecode_o  out  ECODE_W; excp_lane_o  out  2: the winning exception.
REQ-016 retire_cnt_o  out  CNT_W  count of retired instructions.

Function
REQ-017 Stage register: one group of LANES slots, loaded on clk when now_allowin_o=1; slot valid := pre_valid_i & ~excep_flush_o.
REQ-018 now_allowin_o SHALL be ~(|slot_valid) | next_allowin_i, combinational.
REQ-019 The commit cycle is (|slot_valid) & next_allowin_i; when next_allowin_i=0, all slots hold and every commit-side output SHALL be 0.
REQ-020 The winning exception lane k is the lowest-indexed valid slot with excp=1; lanes above k are killed.
REQ-021 In a commit cycle: commit_valid_o[i] = slot_valid[i] & (i<k, or i<=k when k is itself an excp lane); rf_we_o[i] = commit_valid_o[i] & we[i] & ~excp[i]; store_commit_o[i] = same gating with store[i].
REQ-022 An excepting instruction SHALL be reported in commit_valid_o but SHALL NOT write the regfile or release a store.
REQ-023 excep_flush_o SHALL be asserted combinationally in a commit cycle whenever any exception exists; excp_pc_o, excp_ecode_o and excp_lane_o carry lane k values, else 0.
REQ-024 The cycle after a flush, slot_valid SHALL be all-0 regardless of pre_valid_i (flush beats simultaneous load).
REQ-025 Same waddr in two committing lanes: both rf_we bits assert; the regfile SHALL give the higher lane priority (younger wins).
REQ-026 retire_cnt_o += popcount(commit_valid_o) each cycle; modulo 2^CNT_W, wrapping silently.
REQ-027 Latency: input to regfile write is 1 cycle with no stall.
REQ-028 For LANES=1, excp_lane_o = 0 always; for LANES>4, the block is out of scope.

Reset
REQ-029 While rst=1: slot_valid=0, retire_cnt_o=0, all commit/rf/store/excp outputs=0, now_allowin_o=1.
REQ-030 Reset mid-stall SHALL discard the held group with no commit, no store release, and no count increment.

Verification
REQ-031 LANES=2, both valid, no excp, allowin=1 -> next cycle rf_we_o=2'b11, commit_valid_o=2'b11, retire_cnt_o +2.
REQ-032 Lane0 excp ecode=0x08 and lane1 valid -> excep_flush_o=1, excp_lane_o=0, commit_valid_o=2'b01, rf_we_o=0, lane1 killed; next cycle slot_valid=0.
REQ-033 Lane1 store excp, lane0 store -> store_commit_o=2'b01, excp_lane_o=1, retire_cnt_o +2.
REQ-034 next_allowin_i=0 for 3 cycles with a valid group -> outputs 0, now_allowin_o=0, group commits in the cycle allowin returns.
REQ-035 Both lanes write r5 (0x11, 0x22) -> regfile reads 0x22.
REQ-036 Preload retire_cnt_o=2^CNT_W-1 (CNT_W=8 build), commit 2 -> retire_cnt_o=1.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: holds one issue group, retires it in order,
// resolves the oldest exception, and drives regfile, store-release and retire count.
module wb_commit_stage #(
   parameter int LANES   = 2,
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int ECODE_W = 6,
   parameter int CNT_W   = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LANES-1:0]           pre_valid_i,
   input  logic [LANES*DATA_W-1:0]    pre_pc_i,
   input  logic [LANES*DATA_W-1:0]    pre_wdata_i,
   input  logic [LANES-1:0]           pre_we_i,
   input  logic [LANES-1:0]           pre_store_i,
   input  logic [LANES-1:0]           pre_excp_i,
   input  logic [LANES*RADDR_W-1:0]   pre_waddr_i,
   input  logic [LANES*ECODE_W-1:0]   pre_ecode_i,
   input  logic                       next_allowin_i,
   output logic                       now_allowin_o,
   output logic [LANES-1:0]           rf_we_o,
   output logic [LANES*RADDR_W-1:0]   rf_waddr_o,
   output logic [LANES*DATA_W-1:0]    rf_wdata_o,
   output logic [LANES-1:0]           commit_valid_o,
   output logic [LANES*DATA_W-1:0]    commit_pc_o,
   output logic [LANES-1:0]           store_commit_o,
   output logic                       excep_flush_o,
   output logic [DATA_W-1:0]          excp_pc_o,
   output logic [ECODE_W-1:0]         excp_ecode_o,
   output logic [1:0]                 excp_lane_o,
   output logic [CNT_W-1:0]           retire_cnt_o
);

   logic [LANES-1:0]          vld_p0;
   logic [LANES-1:0]          we_p0;
   logic [LANES-1:0]          store_p0;
   logic [LANES-1:0]          excp_p0;
   logic [LANES*DATA_W-1:0]   pc_p0;
   logic [LANES*DATA_W-1:0]   wdata_p0;
   logic [LANES*RADDR_W-1:0]  waddr_p0;
   logic [LANES*ECODE_W-1:0]  ecode_p0;
   logic [CNT_W-1:0]          retire_cnt_q;

   logic commit;
   logic blocked;

   function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   // ---- stage 0: group register (flush kills the incoming group) ----
   always_ff @(posedge clk) begin
      if (rst)
         vld_p0 <= '0;
      else if (now_allowin_o)
         vld_p0 <= pre_valid_i & ~{LANES{excep_flush_o}};
   end

   always_ff @(posedge clk) begin
      if (now_allowin_o) begin
         we_p0    <= pre_we_i;
         store_p0 <= pre_store_i;
         excp_p0  <= pre_excp_i;
         pc_p0    <= pre_pc_i;
         wdata_p0 <= pre_wdata_i;
         waddr_p0 <= pre_waddr_i;
         ecode_p0 <= pre_ecode_i;
      end
   end

   // ---- commit: walk lanes oldest-first, stop after the first exception ----
   always_comb begin
      commit         = (|vld_p0) & next_allowin_i & ~rst;
      now_allowin_o  = rst | ~(|vld_p0) | next_allowin_i;
      blocked        = 1'b0;
      commit_valid_o = '0;
      commit_pc_o    = '0;
      rf_we_o        = '0;
      rf_waddr_o     = '0;
      rf_wdata_o     = '0;
      store_commit_o = '0;
      excep_flush_o  = 1'b0;
      excp_pc_o      = '0;
      excp_ecode_o   = '0;
      excp_lane_o    = '0;
      if (commit) begin
         for (int i = 0; i < LANES; i++) begin
            if (vld_p0[i] && !blocked) begin
               commit_valid_o[i]                 = 1'b1;
               commit_pc_o[i*DATA_W +: DATA_W]   = pc_p0[i*DATA_W +: DATA_W];
               if (excp_p0[i]) begin
                  blocked       = 1'b1;
                  excep_flush_o = 1'b1;
                  excp_pc_o     = pc_p0[i*DATA_W +: DATA_W];
                  excp_ecode_o  = ecode_p0[i*ECODE_W +: ECODE_W];
                  excp_lane_o   = 2'(i);
               end else begin
                  rf_we_o[i]        = we_p0[i];
                  store_commit_o[i] = store_p0[i];
                  if (we_p0[i]) begin
                     rf_waddr_o[i*RADDR_W +: RADDR_W] = waddr_p0[i*RADDR_W +: RADDR_W];
                     rf_wdata_o[i*DATA_W +: DATA_W]   = wdata_p0[i*DATA_W +: DATA_W];
                  end
               end
            end
         end
      end
   end

   // Counter wraps modulo 2^CNT_W by plain overflow.
   always_ff @(posedge clk) begin
      if (rst)
         retire_cnt_q <= '0;
      else
         retire_cnt_q <= retire_cnt_q + popcount(commit_valid_o);
   end

   assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage (LANES=2, CNT_W=8): vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_wb_commit_stage;
   localparam int L  = 2;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int EW = 6;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [L-1:0]  pre_valid_i, pre_we_i, pre_store_i, pre_excp_i;
   logic [L*DW-1:0] pre_pc_i, pre_wdata_i;
   logic [L*AW-1:0] pre_waddr_i;
   logic [L*EW-1:0] pre_ecode_i;
   logic          next_allowin_i;
   logic          now_allowin_o;
   logic [L-1:0]  rf_we_o, commit_valid_o, store_commit_o;
   logic [L*AW-1:0] rf_waddr_o;
   logic [L*DW-1:0] rf_wdata_o, commit_pc_o;
   logic          excep_flush_o;
   logic [DW-1:0] excp_pc_o;
   logic [EW-1:0] excp_ecode_o;
   logic [1:0]    excp_lane_o;
   logic [CW-1:0] retire_cnt_o;

   always #5 clk = ~clk;

   wb_commit_stage #(.LANES(L), .DATA_W(DW), .RADDR_W(AW), .ECODE_W(EW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .pre_valid_i(pre_valid_i), .pre_pc_i(pre_pc_i), .pre_wdata_i(pre_wdata_i),
      .pre_we_i(pre_we_i), .pre_store_i(pre_store_i), .pre_excp_i(pre_excp_i),
      .pre_waddr_i(pre_waddr_i), .pre_ecode_i(pre_ecode_i),
      .next_allowin_i(next_allowin_i), .now_allowin_o(now_allowin_o),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
      .store_commit_o(store_commit_o), .excep_flush_o(excep_flush_o),
      .excp_pc_o(excp_pc_o), .excp_ecode_o(excp_ecode_o), .excp_lane_o(excp_lane_o),
      .retire_cnt_o(retire_cnt_o)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_group(input logic [1:0] v, input logic [1:0] we, input logic [1:0] st,
                            input logic [1:0] ex, input logic [5:0] e0, input logic [5:0] e1,
                            input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] p0, input logic [31:0] p1);
      pre_valid_i = v;   pre_we_i = we;  pre_store_i = st;  pre_excp_i = ex;
      pre_ecode_i = {e1, e0};
      pre_waddr_i = {a1, a0};
      pre_wdata_i = {d1, d0};
      pre_pc_i    = {p1, p0};
   endtask

   task automatic idle();
      set_group(2'b00, 2'b00, 2'b00, 2'b00, 6'h0, 6'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   typedef struct {
      logic [1:0] v, we, st, ex;
      logic [5:0] e0, e1;
      logic [1:0] cv, rwe, sc;
      logic       fl;
      logic [1:0] ln;
      logic [5:0] ec;
      int         inc;
   } vec_t;

   vec_t tbl[8];
   logic [31:0] regfile [32];

   // behavioural model state: the group the stage currently holds
   logic [1:0]  m_v, m_we, m_st, m_ex;
   logic [31:0] m_pc [2];
   logic [31:0] m_wd [2];
   logic [4:0]  m_wa [2];
   logic [5:0]  m_ec [2];
   logic [7:0]  m_cnt;

   initial begin
      logic [7:0]  c0;
      logic [31:0] pc0, pc1;

      rst = 1'b1;
      next_allowin_i = 1'b1;
      set_group(2'b11, 2'b11, 2'b11, 2'b11, 6'h1, 6'h2, 5'd1, 5'd2, 32'h1, 32'h2, 32'h10, 32'h14);

      //            v      we     st     ex     e0     e1     cv     rwe    sc     fl    ln     ec    inc
      tbl[0] = '{2'b11, 2'b11, 2'b00, 2'b00, 6'h00, 6'h00, 2'b11, 2'b11, 2'b00, 1'b0, 2'd0, 6'h00, 2};
      tbl[1] = '{2'b11, 2'b11, 2'b00, 2'b01, 6'h08, 6'h00, 2'b01, 2'b00, 2'b00, 1'b1, 2'd0, 6'h08, 1};
      tbl[2] = '{2'b11, 2'b00, 2'b11, 2'b10, 6'h00, 6'h15, 2'b11, 2'b00, 2'b01, 1'b1, 2'd1, 6'h15, 2};
      tbl[3] = '{2'b10, 2'b10, 2'b00, 2'b00, 6'h00, 6'h00, 2'b10, 2'b10, 2'b00, 1'b0, 2'd0, 6'h00, 1};
      tbl[4] = '{2'b01, 2'b01, 2'b01, 2'b01, 6'h3f, 6'h00, 2'b01, 2'b00, 2'b00, 1'b1, 2'd0, 6'h3f, 1};
      tbl[5] = '{2'b10, 2'b11, 2'b00, 2'b11, 6'h01, 6'h02, 2'b10, 2'b00, 2'b00, 1'b1, 2'd1, 6'h02, 1};
      tbl[6] = '{2'b00, 2'b11, 2'b11, 2'b11, 6'h01, 6'h02, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 6'h00, 0};
      tbl[7] = '{2'b11, 2'b01, 2'b10, 2'b11, 6'h21, 6'h22, 2'b01, 2'b00, 2'b00, 1'b1, 2'd0, 6'h21, 1};

      // reset state
      #1;
      chk("rst_allowin", now_allowin_o, 1'b1);
      chk("rst_cv", commit_valid_o, 2'b00);
      tick();
      chk("rst_cnt", retire_cnt_o, 8'd0);
      chk("rst_cv2", commit_valid_o, 2'b00);
      chk("rst_flush", excep_flush_o, 1'b0);
      chk("rst_allowin2", now_allowin_o, 1'b1);
      rst = 1'b0;
      idle();
      tick();

      // vector table: load one group, then check its commit
      for (int i = 0; i < 8; i++) begin
         pc0 = 32'h1000 + 32'(i * 8);
         pc1 = pc0 + 32'd4;
         set_group(tbl[i].v, tbl[i].we, tbl[i].st, tbl[i].ex, tbl[i].e0, tbl[i].e1,
                   5'd3, 5'd4, 32'hA0 + 32'(i), 32'hB0 + 32'(i), pc0, pc1);
         next_allowin_i = 1'b1;
         tick();
         idle();
         c0 = retire_cnt_o;
         #1;
         chk($sformatf("v%0d_cv", i), commit_valid_o, tbl[i].cv);
         chk($sformatf("v%0d_rfwe", i), rf_we_o, tbl[i].rwe);
         chk($sformatf("v%0d_store", i), store_commit_o, tbl[i].sc);
         chk($sformatf("v%0d_flush", i), excep_flush_o, tbl[i].fl);
         chk($sformatf("v%0d_lane", i), excp_lane_o, tbl[i].ln);
         chk($sformatf("v%0d_ecode", i), excp_ecode_o, tbl[i].ec);
         chk($sformatf("v%0d_epc", i), excp_pc_o,
             tbl[i].fl ? ((tbl[i].ln == 2'd1) ? pc1 : pc0) : 32'h0);
         tick();
         chk($sformatf("v%0d_cnt", i), retire_cnt_o, 8'(c0 + 8'(tbl[i].inc)));
      end

      // stall three cycles with a lane1-excepting group, then flush beats load
      set_group(2'b11, 2'b01, 2'b00, 2'b10, 6'h00, 6'h0c, 5'd7, 5'd8, 32'h77, 32'h88, 32'h2000, 32'h2004);
      tick();
      set_group(2'b11, 2'b11, 2'b11, 2'b00, 6'h00, 6'h00, 5'd9, 5'd9, 32'h99, 32'h99, 32'h3000, 32'h3004);
      next_allowin_i = 1'b0;
      c0 = retire_cnt_o;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk($sformatf("stall%0d_cv", s), commit_valid_o, 2'b00);
         chk($sformatf("stall%0d_allowin", s), now_allowin_o, 1'b0);
         chk($sformatf("stall%0d_flush", s), excep_flush_o, 1'b0);
         chk($sformatf("stall%0d_rfwe", s), rf_we_o, 2'b00);
         tick();
      end
      chk("stall_cnt", retire_cnt_o, c0);
      next_allowin_i = 1'b1;
      #1;
      chk("unstall_cv", commit_valid_o, 2'b11);
      chk("unstall_rfwe", rf_we_o, 2'b01);
      chk("unstall_flush", excep_flush_o, 1'b1);
      chk("unstall_lane", excp_lane_o, 2'd1);
      chk("unstall_epc", excp_pc_o, 32'h2004);
      tick();
      idle();
      #1;
      chk("postflush_cv", commit_valid_o, 2'b00);
      chk("postflush_cnt", retire_cnt_o, 8'(c0 + 8'd2));
      tick();

      // same destination in both lanes: younger lane lands last
      for (int r = 0; r < 32; r++) regfile[r] = 32'h0;
      set_group(2'b11, 2'b11, 2'b00, 2'b00, 6'h0, 6'h0, 5'd5, 5'd5, 32'h11, 32'h22, 32'h40, 32'h44);
      tick();
      idle();
      #1;
      chk("waw_rfwe", rf_we_o, 2'b11);
      chk("waw_addr", rf_waddr_o, {5'd5, 5'd5});
      for (int ln = 0; ln < L; ln++)
         if (rf_we_o[ln]) regfile[rf_waddr_o[ln*AW +: AW]] = rf_wdata_o[ln*DW +: DW];
      chk("waw_r5", regfile[5], 32'h22);
      tick();

      // reset while stalled discards the held group
      set_group(2'b11, 2'b11, 2'b11, 2'b00, 6'h0, 6'h0, 5'd1, 5'd2, 32'h5, 32'h6, 32'h50, 32'h54);
      tick();
      idle();
      next_allowin_i = 1'b0;
      tick();
      rst = 1'b1;
      next_allowin_i = 1'b1;
      #1;
      chk("rststall_cv", commit_valid_o, 2'b00);
      chk("rststall_store", store_commit_o, 2'b00);
      chk("rststall_allowin", now_allowin_o, 1'b1);
      tick();
      rst = 1'b0;
      #1;
      chk("rststall_cv2", commit_valid_o, 2'b00);
      chk("rststall_cnt", retire_cnt_o, 8'd0);
      tick();

      // counter wrap: 127 pairs + 1 single = 255, then one pair -> 1
      set_group(2'b11, 2'b00, 2'b00, 2'b00, 6'h0, 6'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h60, 32'h64);
      for (int n = 0; n < 127; n++) tick();
      pre_valid_i = 2'b01;
      tick();
      pre_valid_i = 2'b11;
      tick();
      chk("wrap_255", retire_cnt_o, 8'd255);
      idle();
      tick();
      chk("wrap_1", retire_cnt_o, 8'd1);

      // randomized traffic against the model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_v = 2'b00;
      m_cnt = 8'd0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         int k;
         logic [1:0] e_cv, e_we, e_st;
         logic e_fl, e_commit, e_allow;
         rst = ($urandom_range(0, 39) == 0);
         next_allowin_i = ($urandom_range(0, 9) < 7);
         set_group(2'($urandom), 2'($urandom), 2'($urandom),
                   ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                   6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
                   $urandom, $urandom, $urandom, $urandom);
         #1;
         // oldest valid exception decides how far the group retires
         k = -1;
         for (int i = 0; i < L; i++) if (k < 0 && m_v[i] && m_ex[i]) k = i;
         e_commit = (m_v != 2'b00) && next_allowin_i && !rst;
         e_allow  = rst || (m_v == 2'b00) || next_allowin_i;
         e_fl     = e_commit && (k >= 0);
         for (int i = 0; i < L; i++) begin
            e_cv[i] = e_commit && m_v[i] && (k < 0 || i <= k);
            e_we[i] = e_cv[i] && m_we[i] && !m_ex[i];
            e_st[i] = e_cv[i] && m_st[i] && !m_ex[i];
         end
         chk("rnd_allowin", now_allowin_o, e_allow);
         chk("rnd_cv", commit_valid_o, e_cv);
         chk("rnd_rfwe", rf_we_o, e_we);
         chk("rnd_store", store_commit_o, e_st);
         chk("rnd_flush", excep_flush_o, e_fl);
         chk("rnd_lane", excp_lane_o, e_fl ? 2'(k) : 2'd0);
         chk("rnd_ecode", excp_ecode_o, e_fl ? m_ec[k] : 6'h0);
         chk("rnd_epc", excp_pc_o, e_fl ? m_pc[k] : 32'h0);
         chk("rnd_cnt", retire_cnt_o, m_cnt);
         for (int i = 0; i < L; i++) begin
            if (e_we[i]) begin
               chk("rnd_waddr", rf_waddr_o[i*AW +: AW], m_wa[i]);
               chk("rnd_wdata", rf_wdata_o[i*DW +: DW], m_wd[i]);
            end
            if (e_cv[i]) chk("rnd_pc", commit_pc_o[i*DW +: DW], m_pc[i]);
         end
         tick();
         if (rst) begin
            m_v = 2'b00;
            m_cnt = 8'd0;
         end else begin
            m_cnt = m_cnt + 8'($countones(e_cv));
            if (e_allow) begin
               m_v  = pre_valid_i & ~{2{e_fl}};
               m_we = pre_we_i;  m_st = pre_store_i;  m_ex = pre_excp_i;
               for (int i = 0; i < L; i++) begin
                  m_pc[i] = pre_pc_i[i*DW +: DW];
                  m_wd[i] = pre_wdata_i[i*DW +: DW];
                  m_wa[i] = pre_waddr_i[i*AW +: AW];
                  m_ec[i] = pre_ecode_i[i*EW +: EW];
               end
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
